wb_arbiter: RTL and testbench

//  Two-master arbiter for the shared 64-bit pipelined Wishbone bus. M0 = CPU core, M1 = debug/DMA master.

---
 rtl/wb_arb_pkg.sv | 22 ++
 rtl/wb_arb_watchdog.sv | 30 +++
 rtl/wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared widths and arbiter state encoding for the Wishbone arbiter
package wb_arb_pkg;

    localparam int WB_ADR_W = 64;
    localparam int WB_DAT_W = 64;
    localparam int WB_SEL_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        OWN0 = ST_OWN0,
        OWN1 = ST_OWN1
    } arb_state_t;

    function automatic logic [1:0] grant_of(input arb_state_t s);
        return {s == OWN1, s == OWN0};
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - ack watchdog, counts stalled-ack cycles and pulses on expiry
// Only instantiated when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // Fires in the cycle that would complete the TIMEOUT_CYCLES-th waiting cycle.
    assign o_expire = i_run & (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (i_clear | ~i_run | o_expire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master round-robin arbiter for the pipelined 64-bit Wishbone bus
// Optional ack watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [WB_ADR_W-1:0] i_m0_adr,
    input  logic [WB_DAT_W-1:0] i_m0_dat,
    output logic [WB_DAT_W-1:0] o_m0_dat,
    input  logic                i_m0_we,
    input  logic [WB_SEL_W-1:0] i_m0_sel,
    input  logic                i_m0_stb,
    input  logic                i_m0_cyc,
    output logic                o_m0_ack,
    output logic                o_m0_stall,
    output logic                o_m0_err,
    input  logic [WB_ADR_W-1:0] i_m1_adr,
    input  logic [WB_DAT_W-1:0] i_m1_dat,
    output logic [WB_DAT_W-1:0] o_m1_dat,
    input  logic                i_m1_we,
    input  logic [WB_SEL_W-1:0] i_m1_sel,
    input  logic                i_m1_stb,
    input  logic                i_m1_cyc,
    output logic                o_m1_ack,
    output logic                o_m1_stall,
    output logic                o_m1_err,
    output logic [WB_ADR_W-1:0] o_s_adr,
    output logic [WB_DAT_W-1:0] o_s_dat,
    output logic                o_s_we,
    output logic [WB_SEL_W-1:0] o_s_sel,
    output logic                o_s_stb,
    output logic                o_s_cyc,
    input  logic [WB_DAT_W-1:0] i_s_dat,
    input  logic                i_s_ack,
    input  logic                i_s_stall,
    output logic [1:0]          o_grant
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       last_owner;
    logic [3:0] outstanding;

    logic own0;
    logic own1;
    logic own_cyc;
    logic own_stb;
    logic cap;
    logic accept;
    logic ack_valid;
    logic owner_change;
    logic expire;

    assign own0    = (state == OWN0);
    assign own1    = (state == OWN1);
    assign own_cyc = own0 ? i_m0_cyc : (own1 ? i_m1_cyc : 1'b0);
    assign own_stb = own0 ? i_m0_stb : (own1 ? i_m1_stb : 1'b0);
    assign cap     = (state != IDLE) && (outstanding == 4'(MAX_OUTSTANDING));

    assign o_s_adr = own1 ? i_m1_adr : i_m0_adr;
    assign o_s_dat = own1 ? i_m1_dat : i_m0_dat;
    assign o_s_we  = own1 ? i_m1_we  : i_m0_we;
    assign o_s_sel = own1 ? i_m1_sel : i_m0_sel;
    assign o_s_cyc = own_cyc & ~expire;
    assign o_s_stb = own_stb & ~cap & ~expire;

    assign accept = o_s_stb & ~i_s_stall;
    // Acks with nothing in flight, or after the owner let go of cyc, belong to nobody.
    assign ack_valid = i_s_ack & own_cyc & (outstanding != 4'd0);

    assign o_m0_ack   = own0 & ack_valid;
    assign o_m1_ack   = own1 & ack_valid;
    assign o_m0_stall = own0 ? (i_s_stall | cap) : 1'b1;
    assign o_m1_stall = own1 ? (i_s_stall | cap) : 1'b1;
    assign o_m0_dat   = i_s_dat;
    assign o_m1_dat   = i_s_dat;
    assign o_m0_err   = own0 & expire;
    assign o_m1_err   = own1 & expire;
    assign o_grant    = grant_of(state);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_m0_cyc && (!i_m1_cyc || last_owner)) begin
                    state_nxt = OWN0;
                end else if (i_m1_cyc) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!i_m0_cyc) begin
                    state_nxt = i_m1_cyc ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!i_m1_cyc) begin
                    state_nxt = i_m0_cyc ? OWN0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign owner_change = (state_nxt != state);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            last_owner  <= 1'b1;
            outstanding <= 4'd0;
        end else begin
            state <= state_nxt;
            if (own0 && !i_m0_cyc) begin
                last_owner <= 1'b0;
            end else if (own1 && !i_m1_cyc) begin
                last_owner <= 1'b1;
            end
            if (owner_change || expire || state == IDLE) begin
                outstanding <= 4'd0;
            end else if (accept && !ack_valid) begin
                outstanding <= outstanding + 4'd1;
            end else if (!accept && ack_valid) begin
                outstanding <= outstanding - 4'd1;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_run     ((outstanding != 4'd0) && !i_s_ack),
        .i_clear   (owner_change),
        .o_expire  (expire)
    );
`else
    // Watchdog compiled out: expiry can never fire.
    assign expire = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and randomized checks of wb_arbiter against a cycle reference model
module tb_wb_arbiter;

    localparam int MAXO = 4;
    localparam int TO   = 16;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] m0_adr, m0_wdat, m0_rdat, m1_adr, m1_wdat, m1_rdat;
    logic        m0_we, m0_stb, m0_cyc, m0_ack, m0_stall, m0_err;
    logic        m1_we, m1_stb, m1_cyc, m1_ack, m1_stall, m1_err;
    logic [7:0]  m0_sel, m1_sel, s_sel;
    logic [63:0] s_adr, s_wdat, s_rdat;
    logic        s_we, s_stb, s_cyc, s_ack, s_stall;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: owner -1 = nobody, 0/1 = master index.
    int owner;
    int last;
    int outs;
    int wd;

    always #5 clk = ~clk;

    wb_arbiter #(.MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m0_adr(m0_adr), .i_m0_dat(m0_wdat), .o_m0_dat(m0_rdat), .i_m0_we(m0_we),
        .i_m0_sel(m0_sel), .i_m0_stb(m0_stb), .i_m0_cyc(m0_cyc), .o_m0_ack(m0_ack),
        .o_m0_stall(m0_stall), .o_m0_err(m0_err),
        .i_m1_adr(m1_adr), .i_m1_dat(m1_wdat), .o_m1_dat(m1_rdat), .i_m1_we(m1_we),
        .i_m1_sel(m1_sel), .i_m1_stb(m1_stb), .i_m1_cyc(m1_cyc), .o_m1_ack(m1_ack),
        .o_m1_stall(m1_stall), .o_m1_err(m1_err),
        .o_s_adr(s_adr), .o_s_dat(s_wdat), .o_s_we(s_we), .o_s_sel(s_sel),
        .o_s_stb(s_stb), .o_s_cyc(s_cyc), .i_s_dat(s_rdat), .i_s_ack(s_ack),
        .i_s_stall(s_stall), .o_grant(grant)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        last  = 1;
        outs  = 0;
        wd    = 0;
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        s_ack = 0; s_stall = 0;
    endtask

    // Called just after a falling edge with inputs set; checks, advances the model, returns at next falling edge.
    task automatic step();
        logic ocyc, ostb, oth, cap, expire, e_scyc, e_sstb, ackv, accept;
        int   nxt;
        #1;
        ocyc   = (owner == 0) ? m0_cyc : ((owner == 1) ? m1_cyc : 1'b0);
        ostb   = (owner == 0) ? m0_stb : ((owner == 1) ? m1_stb : 1'b0);
        oth    = (owner == 0) ? m1_cyc : m0_cyc;
        cap    = (owner >= 0) && (outs == MAXO);
        expire = TO_EN && (owner >= 0) && (outs > 0) && !s_ack && (wd == TO - 1);
        e_scyc = ocyc && !expire;
        e_sstb = ostb && !cap && !expire;
        ackv   = s_ack && ocyc && (outs > 0);
        accept = e_sstb && !s_stall;

        chk("grant", grant, (owner == 0) ? 2'b01 : ((owner == 1) ? 2'b10 : 2'b00));
        chk("s_cyc", s_cyc, e_scyc);
        chk("s_stb", s_stb, e_sstb);
        chk("m0_stall", m0_stall, (owner == 0) ? (s_stall || cap) : 1'b1);
        chk("m1_stall", m1_stall, (owner == 1) ? (s_stall || cap) : 1'b1);
        chk("m0_ack", m0_ack, (owner == 0) && ackv);
        chk("m1_ack", m1_ack, (owner == 1) && ackv);
        chk("m0_err", m0_err, (owner == 0) && expire);
        chk("m1_err", m1_err, (owner == 1) && expire);
        chk("m0_rdat", m0_rdat, s_rdat);
        chk("m1_rdat", m1_rdat, s_rdat);
        if (owner >= 0) begin
            chk("s_adr", s_adr, (owner == 1) ? m1_adr : m0_adr);
            chk("s_wdat", s_wdat, (owner == 1) ? m1_wdat : m0_wdat);
            chk("s_we", s_we, (owner == 1) ? m1_we : m0_we);
            chk("s_sel", s_sel, (owner == 1) ? m1_sel : m0_sel);
        end

        nxt = owner;
        if (owner < 0) begin
            if (m0_cyc && (!m1_cyc || last == 1)) nxt = 0;
            else if (m1_cyc) nxt = 1;
        end else if (!ocyc) begin
            last = owner;
            nxt  = oth ? 1 - owner : -1;
        end
        if (nxt != owner || !(TO_EN && outs > 0 && !s_ack) || expire) wd = 0;
        else wd = wd + 1;
        if (nxt != owner || owner < 0 || expire) outs = 0;
        else outs = outs + int'(accept) - int'(ackv);
        owner = nxt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        m0_adr = '0; m0_wdat = '0; m0_we = 0; m0_sel = 8'hFF;
        m1_adr = '0; m1_wdat = '0; m1_we = 0; m1_sel = 8'hFF;
        s_rdat = '0;
        rst_n = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_cyc", s_cyc, 1'b0);
        chk("rst_s_stb", s_stb, 1'b0);
        chk("rst_m0_stall", m0_stall, 1'b1);
        chk("rst_m1_stall", m1_stall, 1'b1);
        chk("rst_m0_ack", m0_ack, 1'b0);
        chk("rst_m0_err", m0_err, 1'b0);
        rst_n = 1;

        // M0 single read, slave acks two cycles after accept
        m0_cyc = 1; m0_stb = 1; m0_adr = 64'h1_0000_0000; m0_we = 0;
        step();
        #1 chk("t1_grant", grant, 2'b01);
        chk("t1_s_adr", s_adr, 64'h1_0000_0000);
        chk("t1_s_stb", s_stb, 1'b1);
        step();
        m0_stb = 0;
        step();
        s_ack = 1; s_rdat = 64'hA5;
        #1 chk("t1_m0_ack", m0_ack, 1'b1);
        chk("t1_m0_dat", m0_rdat, 64'hA5);
        chk("t1_m1_ack", m1_ack, 1'b0);
        step();
        s_ack = 0; m0_cyc = 0;
        step();
        step();

        // Simultaneous request from reset: M0 first, then direct handoff to M1
        do_reset();
        m0_cyc = 1; m1_cyc = 1;
        step();
        #1 chk("t2_grant_m0", grant, 2'b01);
        step();
        m0_cyc = 0;
        step();
        #1 chk("t2_grant_m1", grant, 2'b10);
        step();
        m1_cyc = 0;
        step();
        step();

        // Outstanding cap with acks withheld
        m0_cyc = 1; m0_stb = 1;
        step();
        for (int i = 0; i < 4; i++) step();
        #1 chk("t3_stall5", m0_stall, 1'b1);
        chk("t3_sstb5", s_stb, 1'b0);
        step();
        #1 chk("t3_stall6", m0_stall, 1'b1);
        step();
        s_ack = 1;
        #1 chk("t3_sstb_capped_ack", s_stb, 1'b0);
        chk("t3_ack_capped", m0_ack, 1'b1);
        step();
        #1 chk("t3_accept_and_ack", s_stb, 1'b1);
        chk("t3_stall_released", m0_stall, 1'b0);
        step();
        s_ack = 0;
        step();
        #1 chk("t3_recapped", m0_stall, 1'b1);
        step();
        m0_stb = 0; m0_cyc = 0;
        step();
        s_ack = 1;
        #1 chk("t3_late_ack", m0_ack, 1'b0);
        step();
        s_ack = 0;

        // Asynchronous reset during an M1 burst
        m1_cyc = 1; m1_stb = 1; m1_adr = 64'hDEAD_0000;
        step();
        step();
        step();
        #3 rst_n = 0;
        #1 chk("t4_s_cyc", s_cyc, 1'b0);
        chk("t4_grant", grant, 2'b00);
        chk("t4_m1_stall", m1_stall, 1'b1);
        model_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        step();

`ifdef WB_ARB_TIMEOUT_EN
        // Unacked read: error pulse 16 cycles after the accept cycle
        m0_cyc = 1; m0_stb = 1;
        step();
        step();
        m0_stb = 0;
        for (int k = 1; k <= 18; k++) begin
            #1 chk($sformatf("t5_err_%0d", k), m0_err, k == TO);
            chk($sformatf("t5_scyc_%0d", k), s_cyc, k != TO);
            step();
        end
        m0_cyc = 0;
        step();
`endif

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (m0_cyc) m0_cyc = ($urandom_range(7) != 0);
            else        m0_cyc = ($urandom_range(3) == 0);
            if (m1_cyc) m1_cyc = ($urandom_range(7) != 0);
            else        m1_cyc = ($urandom_range(3) == 0);
            m0_stb  = m0_cyc && $urandom_range(1);
            m1_stb  = m1_cyc && $urandom_range(1);
            m0_adr  = {$urandom, $urandom}; m0_wdat = {$urandom, $urandom};
            m1_adr  = {$urandom, $urandom}; m1_wdat = {$urandom, $urandom};
            m0_we   = $urandom_range(1);    m1_we   = $urandom_range(1);
            m0_sel  = 8'($urandom);         m1_sel  = 8'($urandom);
            s_rdat  = {$urandom, $urandom};
            s_ack   = ($urandom_range(2) == 0);
            s_stall = ($urandom_range(3) == 0);
            step();
        end
        idle_inputs();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
